// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by fetch_stage, ifid_reg and the instruction memory.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int IMEM_DEPTH_DEF = 128;

  // sll $0,$0,0
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    OOB  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with hold and flush.
// Ports: clk, rst, load, flush, instr, pc_plus1 -> ifid_instr, ifid_pc_plus1, ifid_valid.
module ifid_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus1,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid
);

  // flush keeps pc_plus1: it only tracks captured instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr    <= NOP_WORD;
      ifid_pc_plus1 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else if (flush) begin
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
    end else if (load) begin
      ifid_instr    <= instr;
      ifid_pc_plus1 <= pc_plus1;
      ifid_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, BOOT/RUN/OOB FSM, IF/ID capture.
// Ports: clk, rst, stall, redirect_valid/target, imem_addr/instr,
//   pc, ifid_instr, ifid_pc_plus1, ifid_valid, fetch_oob.
// Optional FETCH_PERF_CNT_EN adds stall_cnt and flush_cnt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_DEPTH = mips_pkg::IMEM_DEPTH_DEF,
  parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        fetch_oob
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  import mips_pkg::*;

  localparam logic [31:0] LIMIT = 32'(IMEM_DEPTH);

  fetch_state_t state;
  fetch_state_t state_nx;
  logic [31:0]  pc_nx;
  logic [31:0]  pc_plus1;
  logic         in_range;
  logic         cap;
  logic         flush;

  assign pc_plus1  = pc + 32'd1;
  assign in_range  = pc < LIMIT;
  assign imem_addr = pc;
  assign fetch_oob = (state == OOB);

  // redirect wins in every state and
  // never range-checks its target
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    cap      = 1'b0;
    flush    = 1'b0;
    if (redirect_valid) begin
      pc_nx    = redirect_target;
      flush    = 1'b1;
      state_nx = RUN;
    end else begin
      unique case (state)
        BOOT: state_nx = RUN;
        RUN: begin
          if (!stall) begin
            if (in_range) begin
              cap   = 1'b1;
              pc_nx = pc_plus1;
            end else begin
              flush    = 1'b1;
              state_nx = OOB;
            end
          end
        end
        OOB: flush = 1'b1;
        default: state_nx = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  ifid_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_ifid (
    .clk          (clk),
    .rst          (rst),
    .load         (cap),
    .flush        (flush),
    .instr        (imem_instr),
    .pc_plus1     (pc_plus1),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid   (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic stall_evt;
  assign stall_evt = (state == RUN) && stall && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_evt && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect_valid && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
